// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP32 multiplier post-multiply stage.
package fp_mul_pkg;

  localparam int FP_MANT_W = 24;
  localparam int FP_EXP_W  = 8;
  localparam int FP_EXPS_W = 10;
  localparam int FRAC_W    = FP_MANT_W - 1;
  // Two spare bits keep the normalise (+1) and round-carry (+1) increments from wrapping.
  localparam int EXPN_W    = FP_EXPS_W + 2;

  localparam int          FP32_BIAS = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;

  localparam logic signed [EXPN_W-1:0] EXPN_TOP  = EXPN_W'(EXP_MAX);
  localparam logic signed [EXPN_W-1:0] EXPN_ZERO = EXPN_W'(0);

  typedef enum logic [1:0] {FP_NORM, FP_ZERO, FP_INF, FP_NAN} fp_class_t;

  typedef struct packed {
    logic                     sign;
    logic signed [EXPN_W-1:0] exp;
    logic [FRAC_W-1:0]        mant;
    logic                     guard;
    logic                     sticky;
    fp_class_t                cls;
  } norm_beat_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised 23-bit fraction; a carry out of the
// fraction wraps it to zero and bumps the exponent.
module fp_round_rne
  import fp_mul_pkg::*;
(
  input  logic [FRAC_W-1:0]        mant,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [EXPN_W-1:0] exp,
  output logic [FRAC_W-1:0]        mant_r,
  output logic signed [EXPN_W-1:0] exp_r
);

  logic round_up;
  logic carry;

  assign round_up        = guard & (sticky | mant[0]);
  assign {carry, mant_r} = {1'b0, mant} + {{FRAC_W{1'b0}}, round_up};
  assign exp_r           = exp + $signed({{(EXPN_W-1){1'b0}}, carry});

endmodule

// File: rtl/fp_mul_norm_round.sv
// FP32 multiply post-stage: S1 normalises the 48-bit product, S2 rounds (RNE) and packs.
// Defining FP_MUL_FLAGS_EN adds the out_flags port {overflow, underflow, inexact}.
module fp_mul_norm_round
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W,
  parameter int EXPS_W = FP_EXPS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXPS_W-1:0]     in_exp,
  input  logic [2*MANT_W-1:0]   in_prod,
  input  logic                  in_zero,
  input  logic                  in_inf,
  input  logic                  in_nan,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef FP_MUL_FLAGS_EN
  output logic [2:0]            out_flags,
`endif
  output logic [31:0]           out_result
);

  localparam int PROD_W = 2 * MANT_W;

  logic       s1_valid;
  logic       s1_advance;
  logic       s2_advance;
  norm_beat_t s1_next;
  norm_beat_t s1_q;

  logic signed [EXPN_W-1:0] exp_ext;
  logic [FRAC_W-1:0]        mant_r;
  logic signed [EXPN_W-1:0] exp_r;
  logic [31:0]              res_word;

  assign s2_advance = !out_valid | out_ready;
  assign s1_advance = !s1_valid | s2_advance;
  assign in_ready   = !s1_valid | s1_advance;

  assign exp_ext = EXPN_W'($signed(in_exp));

  // S1: a product of two normalised mantissas has its leading one at bit 47 or 46.
  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    s1_next      = '0;
    s1_next.sign = in_sign;
    s1_next.cls  = in_nan  ? FP_NAN  :
                   in_inf  ? FP_INF  :
                   in_zero ? FP_ZERO : FP_NORM;
    if (in_prod[PROD_W-1]) begin
      s1_next.mant   = in_prod[PROD_W-2 -: FRAC_W];
      s1_next.guard  = in_prod[PROD_W-2-FRAC_W];
      s1_next.sticky = |in_prod[PROD_W-3-FRAC_W:0];
      s1_next.exp    = exp_ext + EXPN_W'(1);
    end else begin
      s1_next.mant   = in_prod[PROD_W-3 -: FRAC_W];
      s1_next.guard  = in_prod[PROD_W-3-FRAC_W];
      s1_next.sticky = |in_prod[PROD_W-4-FRAC_W:0];
      s1_next.exp    = exp_ext;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= so every register samples its pre-edge inputs.
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; s1_valid alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_q <= s1_next;
    end
  end

  fp_round_rne u_round (
    .mant   (s1_q.mant),
    .guard  (s1_q.guard),
    .sticky (s1_q.sticky),
    .exp    (s1_q.exp),
    .mant_r (mant_r),
    .exp_r  (exp_r)
  );

  // S2: class priority nan > inf > zero > normal; normal results clamp to inf or flush to zero.
  always_comb begin
    res_word = {s1_q.sign, 31'b0};
    unique case (s1_q.cls)
      FP_NAN:  res_word = QNAN;
      FP_INF:  res_word = POS_INF | {s1_q.sign, 31'b0};
      FP_ZERO: res_word = {s1_q.sign, 31'b0};
      FP_NORM: begin
        if (exp_r >= EXPN_TOP) begin
          res_word = POS_INF | {s1_q.sign, 31'b0};
        end else if (exp_r <= EXPN_ZERO) begin
          res_word = {s1_q.sign, 31'b0};
        end else begin
          res_word = {s1_q.sign, exp_r[EXP_W-1:0], mant_r};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_word;
      end
    end
  end

`ifdef FP_MUL_FLAGS_EN
  logic [2:0] res_flags;

  // Inexact reflects the bits dropped before rounding; clamped results are always inexact.
  always_comb begin
    res_flags = 3'b000;
    if (s1_q.cls == FP_NORM) begin
      if (exp_r >= EXPN_TOP) begin
        res_flags = 3'b101;
      end else if (exp_r <= EXPN_ZERO) begin
        res_flags = 3'b011;
      end else begin
        res_flags = {2'b00, s1_q.guard | s1_q.sticky};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags <= '0;
    end else if (s2_advance && s1_valid) begin
      out_flags <= res_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Self-checking bench for fp_mul_norm_round: directed vectors with literal results,
// an arithmetic reference model and a scoreboard compare on every output beat.
module tb_fp_mul_norm_round;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic        in_sign   = 1'b0;
  logic [9:0]  in_exp    = '0;
  logic [47:0] in_prod   = '0;
  logic        in_zero   = 1'b0;
  logic        in_inf    = 1'b0;
  logic        in_nan    = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
`ifdef FP_MUL_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int n_out  = 0;

  logic [34:0] exp_q[$];

  typedef struct {
    logic        s;
    int          e;
    logic [47:0] p;
    logic        z;
    logic        i;
    logic        n;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  vec_t vecs[$];

  fp_mul_norm_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_zero    (in_zero),
    .in_inf     (in_inf),
    .in_nan     (in_nan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef FP_MUL_FLAGS_EN
    .out_flags  (out_flags),
`endif
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Reference: treat the product as an integer, keep the top 24 bits, round the
  // discarded remainder against exactly one half, then range-check the exponent.
  function automatic logic [34:0] model(input logic s, input int e, input logic [47:0] p,
                                        input logic z, input logic i, input logic n);
    int          top;
    int          sh;
    int          ex;
    logic [47:0] q;
    logic [47:0] rem;
    logic [47:0] half;
    logic        inexact;
    if (n) return {3'b000, 32'h7FC0_0000};
    if (i) return {3'b000, s, 8'hFF, 23'h0};
    if (z) return {3'b000, s, 31'h0};
    top = 0;
    for (int b = 0; b < 48; b++) if (p[b]) top = b;
    sh      = top - 23;
    ex      = e + (top - 46);
    q       = p >> sh;
    rem     = p & ((48'd1 << sh) - 48'd1);
    half    = 48'd1 << (sh - 1);
    inexact = (rem != 48'd0);
    if (rem > half || (rem == half && q[0])) q = q + 48'd1;
    if (q == (48'd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {3'b101, s, 8'hFF, 23'h0};
    if (ex <= 0)   return {3'b011, s, 31'h0};
    return {2'b00, inexact, s, 8'(ex), q[22:0]};
  endfunction

  task automatic add_vec(input logic s, input int e, input logic [47:0] p, input logic z,
                         input logic i, input logic n, input logic [31:0] r, input logic [2:0] f);
    vec_t v;
    v.s = s; v.e = e; v.p = p; v.z = z; v.i = i; v.n = n; v.r = r; v.f = f;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_sign  = v.s;
    in_exp   = 10'(v.e);
    in_prod  = v.p;
    in_zero  = v.z;
    in_inf   = v.i;
    in_nan   = v.n;
    in_valid = 1'b1;
  endtask

  task automatic monitor();
    logic [34:0] m;
    logic        held_v = 1'b0;
    logic [31:0] held_r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v) check("hold_stable", out_result, held_r);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", {31'b0, out_valid}, 32'h0);
          end else begin
            m = exp_q.pop_front();
            n_out++;
            check("model_result", out_result, m[31:0]);
`ifdef FP_MUL_FLAGS_EN
            check("model_flags", {29'b0, out_flags}, {29'b0, m[34:32]});
`endif
          end
        end
        held_v = out_valid && !out_ready;
        held_r = out_result;
        if (in_valid && in_ready)
          exp_q.push_back(model(in_sign, int'($signed(in_exp)), in_prod, in_zero, in_inf, in_nan));
      end
    end
  endtask

  task automatic send_one(input vec_t v, input string name);
    int lat;
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    check({name, "_ready"}, {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check({name, "_latency"}, lat, 2);
    check({name, "_result"}, out_result, v.r);
`ifdef FP_MUL_FLAGS_EN
    check({name, "_flags"}, {29'b0, out_flags}, {29'b0, v.f});
`endif
  endtask

  initial begin
    logic [34:0] m;
    int          base;
    int          acc;
    int          tries;
    logic        stall_seen;
    int          bp_idx[4];

    //      sign exp  product            z  i  n  result         flags
    add_vec(0,  127, 48'h400000000000, 0, 0, 0, 32'h3F800000, 3'b000); // 0  1.0*1.0
    add_vec(0,  127, 48'h900000000000, 0, 0, 0, 32'h40100000, 3'b000); // 1  1.5*1.5
    add_vec(0,  127, 48'h400000400000, 0, 0, 0, 32'h3F800000, 3'b001); // 2  tie, even
    add_vec(0,  127, 48'h400000C00000, 0, 0, 0, 32'h3F800002, 3'b001); // 3  tie, odd
    add_vec(0,  127, 48'h400000400001, 0, 0, 0, 32'h3F800001, 3'b001); // 4  above half
    add_vec(0,  127, 48'h7FFFFFC00000, 0, 0, 0, 32'h40000000, 3'b001); // 5  round carry
    add_vec(0,  254, 48'h900000000000, 0, 0, 0, 32'h7F800000, 3'b101); // 6  overflow
    add_vec(0,  254, 48'h7FFFFFC00000, 0, 0, 0, 32'h7F800000, 3'b101); // 7  overflow via carry
    add_vec(0,  254, 48'h400000000000, 0, 0, 0, 32'h7F000000, 3'b000); // 8  largest exponent
    add_vec(0,   -1, 48'h900000000000, 0, 0, 0, 32'h00000000, 3'b011); // 9  underflow
    add_vec(1,   -1, 48'h900000000000, 0, 0, 0, 32'h80000000, 3'b011); // 10 signed underflow
    add_vec(0,    1, 48'h400000000000, 0, 0, 0, 32'h00800000, 3'b000); // 11 smallest normal
    add_vec(0,    0, 48'h400000000000, 0, 0, 0, 32'h00000000, 3'b011); // 12 exp 0 flush
    add_vec(0,  127, 48'h400000000000, 0, 0, 1, 32'h7FC00000, 3'b000); // 13 nan
    add_vec(1,  127, 48'h400000000000, 0, 1, 0, 32'hFF800000, 3'b000); // 14 -inf
    add_vec(0,  127, 48'hFFFFFFFFFFFF, 1, 0, 0, 32'h00000000, 3'b000); // 15 zero
    add_vec(0,  127, 48'h400000000000, 1, 1, 0, 32'h7F800000, 3'b000); // 16 inf beats zero
    add_vec(1,  130, 48'h900000000000, 0, 0, 0, 32'hC1900000, 3'b000); // 17 negative normal
    add_vec(1,  300, 48'h123456789ABC, 1, 1, 1, 32'h7FC00000, 3'b000); // 18 nan beats all

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'h1);
    check("reset_out_result", out_result, 32'h0);
`ifdef FP_MUL_FLAGS_EN
    check("reset_out_flags", {29'b0, out_flags}, 32'h0);
`endif

    for (int k = 0; k < vecs.size(); k++) begin
      m = model(vecs[k].s, vecs[k].e, vecs[k].p, vecs[k].z, vecs[k].i, vecs[k].n);
      check($sformatf("vec%0d_model_result", k), m[31:0], vecs[k].r);
      check($sformatf("vec%0d_model_flags", k), {29'b0, m[34:32]}, {29'b0, vecs[k].f});
    end

    for (int k = 0; k < vecs.size(); k++) send_one(vecs[k], $sformatf("vec%0d", k));

    // Backpressure: consumer stalls for 5 cycles while 4 beats are offered back to back.
    bp_idx     = '{0, 1, 3, 17};
    base       = n_out;
    acc        = 0;
    stall_seen = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int b = 0; b < 4; b++) begin
          drive(vecs[bp_idx[b]]);
          tries = 0;
          @(negedge clk);
          while (!in_ready && tries < 20) begin
            if (!stall_seen) begin
              stall_seen = 1'b1;
              check("bp_stall_after_2", acc, 2);
            end
            @(negedge clk);
            tries++;
          end
          check("bp_accept", {31'b0, in_ready}, 32'h1);
          acc++;
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
    join
    check("bp_stalled", {31'b0, stall_seen}, 32'h1);
    tries = 0;
    while (n_out < base + 4 && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    check("bp_all_out", n_out - base, 4);

    // Reset with two beats in flight: both are dropped.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(vecs[1]);
    @(posedge clk); #1;
    drive(vecs[3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_out_valid", {31'b0, out_valid}, 32'h1);
    base = n_out;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_flush_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_flush_out_result", out_result, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst_no_stale_%0d", c), {31'b0, out_valid}, 32'h0);
    end
    check("rst_no_outputs", n_out - base, 0);

    send_one(vecs[4], "post_reset");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
